data_mem_resp: RTL and testbench

DATA_MEM_RESP -- requirements
Module: data_mem_resp

---
 rtl/mem_pkg.sv | 26 ++
 rtl/data_mem_resp_if.sv | 30 +++
 rtl/sram_1rw.sv | 35 +++
 rtl/data_mem_resp.sv | 133 +++++++++++++
 tb/tb_data_mem_resp.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory response block.
// Contents:
//   state_t     - FSM state encoding (IDLE, BUSY, RESP)
//   LATENCY_DEF - default request-to-response latency in cycles
//   CNT_W       - width of the BUSY-phase latency counter
//   addr_err()  - flags a misaligned or out-of-range word access
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int LATENCY_DEF = 2;
  localparam int CNT_W       = 3;

  // A word access is bad when the byte address is not 4-aligned or the
  // word index addr[31:2] falls outside the array.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
    logic [31:0] index;
    index    = {2'b00, addr[31:2]};
    addr_err = (addr[1:0] != 2'b00) || (index >= depth);
  endfunction

endpackage

// File: rtl/data_mem_resp_if.sv
// Request/response bus between the pipeline memory stage and data_mem_resp.
// Signals:
//   req_valid, req_write, req_addr, req_wdata - request from the pipeline
//   req_ready                                 - block accepts a request
//   resp_valid, resp_rdata, resp_err          - one-cycle completion
//   stall                                     - freeze request to hazard unit
// Modports: master = pipeline side, slave = memory block side.
interface data_mem_resp_if;

  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        stall;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, stall
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, stall
  );

endinterface

// File: rtl/sram_1rw.sv
// Single-port word array: synchronous write, registered read.
// Ports:
//   clk   - clock
//   en    - access enable for this edge
//   we    - 1 = write wdata at addr, 0 = register mem[addr] into rdata
//   addr  - word index
//   wdata - write data
//   rdata - registered read data (holds until the next read)
// Contents are never reset.
module sram_1rw #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 32,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/data_mem_resp.sv
// Data-memory access block for the pipeline memory stage.
// Accepts one load/store in IDLE, waits LATENCY cycles (IDLE -> BUSY -> RESP,
// or IDLE -> RESP when LATENCY is 1), then pulses a one-cycle response.
// Ports:
//   clk - clock, rising edge
//   rst - asynchronous active-low reset
//   bus - request/response bus (slave side)
// Parameters:
//   DEPTH   - number of 32-bit words
//   LATENCY - accept-to-response cycles, 1..7
module data_mem_resp
  import mem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic           clk,
  input  logic           rst,
  data_mem_resp_if.slave bus
);

  localparam int               AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ready;
  logic             accept;
  logic             go_resp;
  logic             in_resp;

  logic [31:0]      addr_p1;
  logic [31:0]      wdata_p1;
  logic             write_p1;

  logic [31:0]      acc_addr;
  logic [31:0]      acc_wdata;
  logic             acc_write;
  logic             mem_en;
  logic [31:0]      mem_rdata;
  logic             resp_err_int;

  // Ready is forced low while reset is asserted, independent of the state.
  assign ready   = (state == IDLE) && rst;
  assign accept  = ready && bus.req_valid;
  assign in_resp = (state == RESP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Counter starts at 1 on accept so BUSY lasts LATENCY-1 cycles.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_nxt = RESP;
            cnt_nxt   = '0;
          end else begin
            state_nxt = BUSY;
            cnt_nxt   = CNT_W'(1);
          end
        end
      end
      BUSY: begin
        if (cnt == CNT_LAST) begin
          state_nxt = RESP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RESP: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Request capture stage: data registers carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p1  <= bus.req_addr;
      wdata_p1 <= bus.req_wdata;
      write_p1 <= bus.req_write;
    end
  end

  // The array is touched on the edge entering RESP. With LATENCY 1 that is
  // the accept edge itself, so the access comes straight from the bus.
  assign go_resp   = (state_nxt == RESP) && rst;
  assign acc_addr  = (state == IDLE) ? bus.req_addr  : addr_p1;
  assign acc_wdata = (state == IDLE) ? bus.req_wdata : wdata_p1;
  assign acc_write = (state == IDLE) ? bus.req_write : write_p1;
  assign mem_en    = go_resp && !addr_err(acc_addr, DEPTH);

  sram_1rw #(
    .DEPTH  (DEPTH),
    .DATA_W (32),
    .AW     (AW)
  ) u_sram (
    .clk   (clk),
    .en    (mem_en),
    .we    (acc_write),
    .addr  (acc_addr[AW+1:2]),
    .wdata (acc_wdata),
    .rdata (mem_rdata)
  );

  // Response stage: data only on a good load, zero otherwise.
  assign resp_err_int   = in_resp && addr_err(addr_p1, DEPTH);
  assign bus.req_ready  = ready;
  assign bus.resp_valid = in_resp;
  assign bus.resp_err   = resp_err_int;
  assign bus.resp_rdata = (in_resp && !resp_err_int && !write_p1) ? mem_rdata : '0;
  assign bus.stall      = bus.req_valid && !in_resp;

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp: three instances with LATENCY 2, 3 and 1.
module tb_data_mem_resp;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  data_mem_resp_if b2();
  data_mem_resp_if b3();
  data_mem_resp_if b1();

  data_mem_resp #(.DEPTH(256), .LATENCY(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));
  data_mem_resp #(.DEPTH(256), .LATENCY(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));
  data_mem_resp #(.DEPTH(256), .LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One LATENCY-2 transaction; junk request held during BUSY must be ignored.
  task automatic txn2(input string tag, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] exp_rd,
                      input logic exp_err);
    b2.req_valid = 1'b1;
    b2.req_write = w;
    b2.req_addr  = a;
    b2.req_wdata = d;
    #1;
    chk({tag, ":ready_idle"}, b2.req_ready, 1);
    chk({tag, ":stall_idle"}, b2.stall, 1);
    step();
    chk({tag, ":rv_busy"}, b2.resp_valid, 0);
    chk({tag, ":ready_busy"}, b2.req_ready, 0);
    b2.req_write = 1'b1;
    b2.req_addr  = 32'h0000_0010;
    b2.req_wdata = 32'hFFFF_FFFF;
    #1;
    chk({tag, ":stall_busy"}, b2.stall, 1);
    step();
    chk({tag, ":rv_resp"}, b2.resp_valid, 1);
    chk({tag, ":err_resp"}, b2.resp_err, exp_err);
    if (!w || exp_err) chk({tag, ":rdata_resp"}, b2.resp_rdata, exp_rd);
    chk({tag, ":stall_resp"}, b2.stall, 0);
    b2.req_valid = 1'b0;
    step();
    chk({tag, ":rv_after"}, b2.resp_valid, 0);
    chk({tag, ":rdata_after"}, b2.resp_rdata, 0);
    chk({tag, ":err_after"}, b2.resp_err, 0);
    chk({tag, ":ready_after"}, b2.req_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b0;
    b2.req_valid = 0; b2.req_write = 0; b2.req_addr = 0; b2.req_wdata = 0;
    b3.req_valid = 0; b3.req_write = 0; b3.req_addr = 0; b3.req_wdata = 0;
    b1.req_valid = 0; b1.req_write = 0; b1.req_addr = 0; b1.req_wdata = 0;

    // Reset state
    step();
    step();
    chk("rst:ready", b2.req_ready, 0);
    chk("rst:rv", b2.resp_valid, 0);
    chk("rst:rdata", b2.resp_rdata, 0);
    chk("rst:err", b2.resp_err, 0);
    chk("rst:stall0", b2.stall, 0);
    chk("rst:ready3", b3.req_ready, 0);
    chk("rst:ready1", b1.req_ready, 0);
    b2.req_valid = 1'b1;
    #1;
    chk("rst:stall1", b2.stall, 1);
    chk("rst:ready_v", b2.req_ready, 0);
    b2.req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst:ready_rise", b2.req_ready, 1);
    chk("rst:ready_rise3", b3.req_ready, 1);

    // LATENCY 2: store/load, misaligned, out of range, top word
    txn2("st10", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0);
    txn2("ld10", 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0);
    txn2("st12", 1'b1, 32'h0000_0012, 32'hCAFE_F00D, 32'h0, 1'b1);
    txn2("ld10b", 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0);
    txn2("ld400", 1'b0, 32'h0000_0400, 32'h0, 32'h0, 1'b1);
    txn2("st3fc", 1'b1, 32'h0000_03FC, 32'h5A5A_1234, 32'h0, 1'b0);
    txn2("ld3fc", 1'b0, 32'h0000_03FC, 32'h0, 32'h5A5A_1234, 1'b0);
    txn2("st20", 1'b1, 32'h0000_0020, 32'h0BAD_F00D, 32'h0, 1'b0);
    txn2("ld20", 1'b0, 32'h0000_0020, 32'h0, 32'h0BAD_F00D, 1'b0);

    // Reset one cycle after accepting a store: must not commit
    b2.req_valid = 1'b1;
    b2.req_write = 1'b1;
    b2.req_addr  = 32'h0000_0020;
    b2.req_wdata = 32'h1234_5678;
    #1;
    chk("mrst:ready", b2.req_ready, 1);
    step();
    rst = 1'b0;
    b2.req_valid = 1'b0;
    #1;
    chk("mrst:rv0", b2.resp_valid, 0);
    chk("mrst:ready0", b2.req_ready, 0);
    step();
    chk("mrst:rv1", b2.resp_valid, 0);
    step();
    chk("mrst:rv2", b2.resp_valid, 0);
    rst = 1'b1;
    #1;
    chk("mrst:ready_rise", b2.req_ready, 1);
    txn2("ld20r", 1'b0, 32'h0000_0020, 32'h0, 32'h0BAD_F00D, 1'b0);

    // LATENCY 3 stall profile with req_valid held high
    b3.req_valid = 1'b1;
    b3.req_write = 1'b1;
    b3.req_addr  = 32'h0000_0004;
    b3.req_wdata = 32'h1111_2222;
    #1;
    chk("l3:stall_c0", b3.stall, 1);
    chk("l3:ready_c0", b3.req_ready, 1);
    step();
    chk("l3:stall_c1", b3.stall, 1);
    chk("l3:ready_c1", b3.req_ready, 0);
    chk("l3:rv_c1", b3.resp_valid, 0);
    step();
    chk("l3:stall_c2", b3.stall, 1);
    chk("l3:rv_c2", b3.resp_valid, 0);
    step();
    chk("l3:stall_resp", b3.stall, 0);
    chk("l3:rv_resp", b3.resp_valid, 1);
    chk("l3:err_resp", b3.resp_err, 0);
    b3.req_write = 1'b0;
    #1;
    step();
    chk("l3:ready_next", b3.req_ready, 1);
    chk("l3:stall_next", b3.stall, 1);
    chk("l3:rv_next", b3.resp_valid, 0);
    step();
    chk("l3:ready_acc2", b3.req_ready, 0);
    b3.req_valid = 1'b0;
    step();
    chk("l3:rv_b2", b3.resp_valid, 0);
    step();
    chk("l3:rv_ld", b3.resp_valid, 1);
    chk("l3:rdata_ld", b3.resp_rdata, 32'h1111_2222);
    step();
    chk("l3:rv_end", b3.resp_valid, 0);

    // LATENCY 1 back-to-back: response every second cycle
    b1.req_valid = 1'b1;
    b1.req_write = 1'b1;
    b1.req_addr  = 32'h0000_0008;
    b1.req_wdata = 32'hA5A5_A5A5;
    #1;
    chk("l1:ready_c0", b1.req_ready, 1);
    chk("l1:rv_c0", b1.resp_valid, 0);
    step();
    chk("l1:rv_c1", b1.resp_valid, 1);
    chk("l1:ready_c1", b1.req_ready, 0);
    chk("l1:stall_c1", b1.stall, 0);
    chk("l1:err_c1", b1.resp_err, 0);
    b1.req_write = 1'b0;
    step();
    chk("l1:rv_c2", b1.resp_valid, 0);
    chk("l1:ready_c2", b1.req_ready, 1);
    chk("l1:stall_c2", b1.stall, 1);
    step();
    chk("l1:rv_c3", b1.resp_valid, 1);
    chk("l1:rdata_c3", b1.resp_rdata, 32'hA5A5_A5A5);
    b1.req_addr = 32'h0000_000A;
    step();
    chk("l1:rv_c4", b1.resp_valid, 0);
    chk("l1:rdata_c4", b1.resp_rdata, 0);
    step();
    chk("l1:rv_c5", b1.resp_valid, 1);
    chk("l1:err_c5", b1.resp_err, 1);
    chk("l1:rdata_c5", b1.resp_rdata, 0);
    b1.req_valid = 1'b0;
    step();
    chk("l1:rv_c6", b1.resp_valid, 0);
    chk("l1:ready_c6", b1.req_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
